// File: rtl/pc_trace_pkg.sv
// Shared definitions for the PC trace buffer: capture FSM encodings and cycle-stamp width.
package pc_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_CAPTURE = 2'b01,
        ST_FROZEN  = 2'b10
    } trace_state_e;

    localparam int CYCLE_W = 16;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x DW array, one write port and one registered read port.
// The read register is reset so nothing from the uninitialised array is exposed before a read.
module trace_ram #(
    parameter int DW    = 9,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Array write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= {DW{1'b0}};
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/pc_trace_buffer.sv
// Captures the CPU program counter on every instruction-fetch-1 entry, freezes on halt or full.
// Define PC_TRACE_CYCLE_EN to stamp each entry with a 16-bit cycle count and expose rd_cycle.
module pc_trace_buffer
    import pc_trace_pkg::*;
#(
    parameter int                 PC_W     = 9,
    parameter int                 DEPTH    = 16,
    parameter int                 STATE_W  = 4,
    parameter logic [STATE_W-1:0] IF1_CODE = 4'b0001
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic [STATE_W-1:0]       cpu_state,
    input  logic [PC_W-1:0]          cpu_pc,
    input  logic                     halt,
    input  logic                     arm,
    input  logic                     wrap,
    input  logic                     rd_en,
    output logic [PC_W-1:0]          rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
`ifdef PC_TRACE_CYCLE_EN
    output logic [CYCLE_W-1:0]       rd_cycle,
`endif
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef PC_TRACE_CYCLE_EN
    localparam int EW = PC_W + CYCLE_W;
`else
    localparam int EW = PC_W;
`endif
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_AW = {{(AW-1){1'b0}}, 1'b1};

    trace_state_e  state_r, state_s;
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [CW-1:0] count_r, count_s;
    logic          overflow_r, overflow_s;
    logic          done_r, done_s;
    logic          rd_valid_r;
    logic          prev_match_r;
    logic          prev_halt_r;
    logic          match_s, fetch_s, halt_edge_s;
    logic          we_s, re_s;
    logic [EW-1:0] wdata_s, rdata_s;

    assign match_s     = (cpu_state == IF1_CODE);
    assign fetch_s     = match_s & ~prev_match_r;
    assign halt_edge_s = halt & ~prev_halt_r;

`ifdef PC_TRACE_CYCLE_EN
    logic [CYCLE_W-1:0] cycle_r;

    // Free-running cycle stamp
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cycle_r <= {CYCLE_W{1'b0}};
        end else begin
            cycle_r <= cycle_r + {{(CYCLE_W-1){1'b0}}, 1'b1};
        end
    end

    assign wdata_s  = {cycle_r, cpu_pc};
    assign rd_cycle = rdata_s[EW-1:PC_W];
    assign rd_data  = rdata_s[PC_W-1:0];
`else
    assign wdata_s  = cpu_pc;
    assign rd_data  = rdata_s;
`endif

    // Next-state, pointer and flag logic for the capture FSM
    always_comb begin
        state_s    = state_r;
        wr_ptr_s   = wr_ptr_r;
        rd_ptr_s   = rd_ptr_r;
        count_s    = count_r;
        overflow_s = overflow_r;
        done_s     = done_r;
        we_s       = 1'b0;
        re_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arm) begin
                    state_s    = ST_CAPTURE;
                    wr_ptr_s   = {AW{1'b0}};
                    rd_ptr_s   = {AW{1'b0}};
                    count_s    = {CW{1'b0}};
                    overflow_s = 1'b0;
                    done_s     = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (fetch_s) begin
                    if (count_r != FULL_C) begin
                        we_s     = 1'b1;
                        wr_ptr_s = wr_ptr_r + ONE_AW;
                        count_s  = count_r + ONE_CW;
                    end else if (wrap) begin
                        // Ring mode: the write lands on the oldest slot, so the read side moves with it
                        we_s       = 1'b1;
                        wr_ptr_s   = wr_ptr_r + ONE_AW;
                        rd_ptr_s   = rd_ptr_r + ONE_AW;
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = 1'b1;
                        state_s    = ST_FROZEN;
                        done_s     = 1'b0;
                    end
                end else begin
                    state_s = ST_CAPTURE;
                end
                // A halt edge freezes after any fetch of the same cycle has been taken
                if (halt_edge_s) begin
                    state_s = ST_FROZEN;
                    done_s  = 1'b1;
                end else begin
                    done_s = done_s;
                end
            end
            ST_FROZEN: begin
                if (arm) begin
                    state_s    = ST_CAPTURE;
                    wr_ptr_s   = {AW{1'b0}};
                    rd_ptr_s   = {AW{1'b0}};
                    count_s    = {CW{1'b0}};
                    overflow_s = 1'b0;
                    done_s     = 1'b0;
                end else if (rd_en && (count_r != {CW{1'b0}})) begin
                    re_s     = 1'b1;
                    rd_ptr_s = rd_ptr_r + ONE_AW;
                    count_s  = count_r - ONE_CW;
                end else begin
                    state_s = ST_FROZEN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, flag and edge-detect registers
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {AW{1'b0}};
            rd_ptr_r     <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            overflow_r   <= 1'b0;
            done_r       <= 1'b0;
            rd_valid_r   <= 1'b0;
            prev_match_r <= 1'b0;
            prev_halt_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            count_r      <= count_s;
            overflow_r   <= overflow_s;
            done_r       <= done_s;
            rd_valid_r   <= re_s;
            prev_match_r <= match_s;
            prev_halt_r  <= halt;
        end
    end

    trace_ram #(
        .DW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_trace_ram (
        .clk   (CLOCK_50),
        .rst_n (reset_n),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (wdata_s),
        .re    (re_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    assign count    = count_r;
    assign overflow = overflow_r;
    assign done     = done_r;
    assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Bench for pc_trace_buffer: directed scenarios plus random traffic against a queue-based model.
// Builds with or without PC_TRACE_CYCLE_EN.
module tb_pc_trace_buffer;

    localparam int         PC_W  = 9;
    localparam int         DEPTH = 16;
    localparam logic [3:0] IF1   = 4'b0001;
    localparam int M_IDLE = 0;
    localparam int M_CAP  = 1;
    localparam int M_FRZ  = 2;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic [3:0]  cpu_state = 4'h0;
    logic [8:0]  cpu_pc = 9'h000;
    logic        halt = 1'b0;
    logic        arm = 1'b0;
    logic        wrap = 1'b0;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        overflow;
    logic        done;
`ifdef PC_TRACE_CYCLE_EN
    logic [15:0] rd_cycle;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the trace is a queue of (pc, cycle) pairs
    int m_state = M_IDLE;
    int m_pc_q[$];
    int m_cyc_q[$];
    int m_ovf = 0, m_done = 0, m_rd_valid = 0, m_rd_data = 0, m_rd_cyc = 0;
    int m_prev_if1 = 0, m_prev_halt = 0, m_cycle = 0;
    int got_q[$];
    int got_cyc_q[$];

    pc_trace_buffer dut (
        .CLOCK_50  (CLOCK_50),
        .reset_n   (reset_n),
        .cpu_state (cpu_state),
        .cpu_pc    (cpu_pc),
        .halt      (halt),
        .arm       (arm),
        .wrap      (wrap),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .overflow  (overflow),
`ifdef PC_TRACE_CYCLE_EN
        .rd_cycle  (rd_cycle),
`endif
        .done      (done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_pc_q.delete();
        m_cyc_q.delete();
        m_ovf  = 0;
        m_done = 0;
    endtask

    task automatic compare_outputs();
        chk("count", 32'(count), 32'(m_pc_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("done", 32'(done), 32'(m_done));
        chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        chk("rd_data", 32'(rd_data), 32'(m_rd_data));
`ifdef PC_TRACE_CYCLE_EN
        chk("rd_cycle", 32'(rd_cycle), 32'(m_rd_cyc));
`endif
    endtask

    task automatic step();
        bit fetch, hedge;
        fetch = (cpu_state == IF1) && (m_prev_if1 == 0);
        hedge = halt && (m_prev_halt == 0);
        m_rd_valid = 0;
        case (m_state)
            M_IDLE: begin
                if (arm) begin
                    model_clear();
                    m_state = M_CAP;
                end
            end
            M_CAP: begin
                if (fetch) begin
                    if (m_pc_q.size() < DEPTH) begin
                        m_pc_q.push_back(int'(cpu_pc));
                        m_cyc_q.push_back(m_cycle);
                    end else if (wrap) begin
                        void'(m_pc_q.pop_front());
                        void'(m_cyc_q.pop_front());
                        m_pc_q.push_back(int'(cpu_pc));
                        m_cyc_q.push_back(m_cycle);
                        m_ovf = 1;
                    end else begin
                        m_ovf   = 1;
                        m_done  = 0;
                        m_state = M_FRZ;
                    end
                end
                if (hedge) begin
                    m_state = M_FRZ;
                    m_done  = 1;
                end
            end
            M_FRZ: begin
                if (arm) begin
                    model_clear();
                    m_state = M_CAP;
                end else if (rd_en && m_pc_q.size() > 0) begin
                    m_rd_data  = m_pc_q.pop_front();
                    m_rd_cyc   = m_cyc_q.pop_front();
                    m_rd_valid = 1;
                end
            end
            default: m_state = M_IDLE;
        endcase
        m_prev_if1  = (cpu_state == IF1) ? 1 : 0;
        m_prev_halt = halt ? 1 : 0;
        m_cycle     = (m_cycle + 1) & 16'hFFFF;
        @(posedge CLOCK_50);
        #1;
        compare_outputs();
        if (rd_valid) begin
            got_q.push_back(int'(rd_data));
`ifdef PC_TRACE_CYCLE_EN
            got_cyc_q.push_back(int'(rd_cycle));
`endif
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        model_clear();
        m_state = M_IDLE;
        m_rd_valid = 0; m_rd_data = 0; m_rd_cyc = 0;
        m_prev_if1 = 0; m_prev_halt = 0; m_cycle = 0;
        compare_outputs();
        @(negedge CLOCK_50);
        reset_n = 1'b1;
    endtask

    task automatic do_arm(input logic w);
        wrap = w;
        arm  = 1'b1;
        step();
        arm  = 1'b0;
    endtask

    task automatic fetch(input int pc);
        cpu_state = IF1;
        cpu_pc    = 9'(pc);
        step();
        cpu_state = 4'h0;
        step();
    endtask

    task automatic halt_pulse();
        halt = 1'b1;
        step();
        halt = 1'b0;
        step();
    endtask

    task automatic drain();
        got_q.delete();
        got_cyc_q.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (m_pc_q.size() == 0 || m_state != M_FRZ) break;
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        step();
    endtask

    initial begin
        do_reset();
        step();

        // Basic capture of four fetches, freeze on halt, read back in order
        do_arm(1'b0);
        for (int i = 0; i < 4; i++) fetch(i);
        halt_pulse();
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_count", 32'(count), 32'd4);
        drain();
        chk("basic_nread", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("basic_rd", 32'(got_q[i]), 32'(i));
        chk("basic_empty", 32'(count), 32'd0);

        // IF1 held for three cycles counts once
        do_arm(1'b0);
        cpu_state = IF1; cpu_pc = 9'd5;
        for (int i = 0; i < 3; i++) step();
        cpu_state = 4'h0;
        step();
        halt_pulse();
        chk("hold_count", 32'(count), 32'd1);
        drain();
        chk("hold_nread", 32'(got_q.size()), 32'd1);
        chk("hold_rd", 32'(got_q[0]), 32'd5);

        // Ring mode: 20 fetches keep the newest 16
        do_arm(1'b1);
        for (int i = 0; i < 20; i++) fetch(i);
        halt_pulse();
        chk("ring_ovf", 32'(overflow), 32'd1);
        chk("ring_count", 32'(count), 32'd16);
        drain();
        chk("ring_nread", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("ring_rd", 32'(got_q[i]), 32'(i + 4));

        // Stop mode: the 17th fetch is dropped and the buffer freezes without done
        do_arm(1'b0);
        for (int i = 0; i < 17; i++) fetch(i);
        chk("stop_ovf", 32'(overflow), 32'd1);
        chk("stop_done", 32'(done), 32'd0);
        chk("stop_count", 32'(count), 32'd16);
        drain();
        chk("stop_nread", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) chk("stop_rd", 32'(got_q[i]), 32'(i));

        // Reset mid-capture discards everything; reads are ignored afterwards
        do_arm(1'b0);
        for (int i = 0; i < 3; i++) fetch(i + 7);
        chk("abort_pre", 32'(count), 32'd3);
        do_reset();
        chk("abort_count", 32'(count), 32'd0);
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;
        chk("abort_rdv", 32'(rd_valid), 32'd0);
        chk("abort_cnt2", 32'(count), 32'd0);

        // Fetch and halt edge together: the fetch is kept, then freeze
        do_arm(1'b0);
        fetch(9'h010);
        fetch(9'h011);
        cpu_state = IF1; cpu_pc = 9'h01A; halt = 1'b1;
        step();
        cpu_state = 4'h0; halt = 1'b0;
        step();
        chk("same_done", 32'(done), 32'd1);
        chk("same_count", 32'(count), 32'd3);
        drain();
        chk("same_nread", 32'(got_q.size()), 32'd3);
        chk("same_last", 32'(got_q[2]), 32'h01A);
`ifdef PC_TRACE_CYCLE_EN
        chk("same_cyc01", 32'(got_cyc_q[1] > got_cyc_q[0]), 32'd1);
        chk("same_cyc12", 32'(got_cyc_q[2] > got_cyc_q[1]), 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset();
            arm = ($urandom_range(0, 99) < 3);
            if (arm) wrap = 1'($urandom_range(0, 1));
            cpu_state = ($urandom_range(0, 2) == 0) ? IF1 : 4'($urandom_range(0, 15));
            cpu_pc = 9'($urandom);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            rd_en = 1'($urandom_range(0, 1));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
